muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit alongside the single-cycle ALU in the execute stage. It takes the same srca/srcb operands the ALU receives.
- Implements MULT, MULTU, DIV and DIVU into architectural HI/LO registers, plus MTHI/MTLO writes.
- Asserts busy so the controller stalls any MFHI/MFLO or new mul/div until the result is ready.
- Its HI/LO outputs feed the writeback result mux.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- Iteration count equals WIDTH. All values below are for WIDTH=32.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  launch an operation; sampled only when not busy.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  multiplicand / dividend (rs).
- b  input  WIDTH  multiplier / divisor (rt).
- mthi  input  1  write wdata to HI.
- mtlo  input  1  write wdata to LO.
- wdata  input  WIDTH  data for MTHI/MTLO.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: HI/LO hold a new result.

Behaviour:
- Reset (async, takes effect immediately, including mid-operation):
  - State goes to IDLE.
  - hi, lo and all internal registers are 0.
  - busy and done are 0.
  - An aborted operation never writes HI/LO.
- States: IDLE, RUN, FIX, DONE.
- busy = 1 in RUN and FIX. done = 1 in DONE only.
- IDLE or DONE, start=1 at edge E0:
  - Latch op and the sign flags sa=a[31], sb=b[31] (both forced 0 for MULTU/DIVU).
  - Latch magnitudes |a| and |b| (two's-complement negate if the sign flag is set).
  - Set counter=0 and go to RUN.
- RUN: one iteration per edge, at E1..E32. Counter increments each iteration; at counter=31 the next state is FIX.
- Multiply iteration: shift-add on a 64-bit product register. If the multiplier LSB is 1, add |a| into the upper half with carry; then shift the product right 1.
- Divide iteration: restoring division.
  - Shift the {rem, quot} pair left 1.
  - Trial-subtract |b| from rem (33-bit compare).
  - If non-negative, keep the difference and set quot LSB=1.
- FIX (edge E33): apply signs and write HI/LO.
  - Multiply: if sa^sb, negate the 64-bit product. hi=product[63:32], lo=product[31:0].
  - Divide: lo = quotient, negated if sa^sb. hi = remainder, negated if sa.
  - Next state DONE.
- Latency: HI/LO valid and done=1 in the cycle after E33, i.e. 33 edges after the start edge.
- DONE: lasts one cycle. Next state is IDLE, or RUN if start=1 (back-to-back launch allowed).
- Divide by zero: no trap. Same latency. Result is lo=FFFFFFFF, hi=a (original signed dividend).
- DIV 80000000 / FFFFFFFF: lo=80000000, hi=00000000. This falls out of the magnitude algorithm with no special case.
- start while busy: ignored. Latched operands and op are unaffected.
- mthi/mtlo:
  - Honoured only in IDLE or DONE; the register is written at the next edge.
  - Ignored while busy.
  - If start=1 in the same cycle, start has priority and the move is dropped.
  - mthi and mtlo together write both registers.
- Operand capture: a and b are sampled only at the start edge. Later changes have no effect.
- HI/LO hold their value in every state except at the FIX edge or an accepted move.

Test Plan:
- MULTU a=FFFFFFFF b=FFFFFFFF:
  - busy high for exactly 33 cycles after the start edge.
  - done pulses once.
  - hi=FFFFFFFE, lo=00000001.
- MULT a=FFFFFFFD (-3) b=00000007 -> hi=FFFFFFFF, lo=FFFFFFEB. MULT a=0 b=12345678 -> hi=0, lo=0.
- DIV cases:
  - DIV a=FFFFFFF9 (-7) b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF.
  - DIVU a=FFFFFFF9 b=00000002 -> lo=7FFFFFFC, hi=00000001.
  - DIV a=80000000 b=FFFFFFFF -> lo=80000000, hi=0.
- DIVU a=00000064 b=0 -> lo=FFFFFFFF, hi=00000064, with the same 33-cycle latency.
- Start ignored while busy:
  - Launch MULTU 3*5.
  - At cycle 10, pulse start with op=DIVU and change a/b; also pulse mthi with wdata=AAAAAAAA.
  - Required: hi=0, lo=0000000F, and only one done pulse.
  - Then, in IDLE, mtlo with wdata=12345678 -> lo=12345678 on the next edge.
- Reset and back-to-back:
  - Preload hi/lo via mthi/mtlo, then assert reset asynchronously at cycle 20 of a DIV.
  - Required: hi=lo=0 and busy=0 immediately.
  - After release, a new MULTU 2*3 gives lo=6.
  - Start asserted in the DONE cycle is accepted: busy is high on the next cycle.

Source files
------------

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_unit_if : command/result bundle between execute stage and muldiv.   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output hi, lo, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_unit : iterative MULT/MULTU/DIV/DIVU into HI/LO, plus MTHI/MTLO.    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic    clk,
  input  wire logic    reset,
  muldiv_unit_if.slave bus
);
  localparam int               CNT_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_div;
  logic               r_sa;
  logic               r_sb;
  logic               r_bzero;
  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mag_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_idle_like;
  logic               w_accept;
  logic               w_move;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_step;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [2*WIDTH-1:0] w_div_step;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_accept    = w_idle_like && bus.start;
  assign w_move      = w_idle_like && !bus.start;

  // op[0] set means unsigned, so sign flags are forced to zero
  assign w_sa    = ~bus.op[0] & bus.a[WIDTH-1];
  assign w_sb    = ~bus.op[0] & bus.b[WIDTH-1];
  assign w_abs_a = w_sa ? -bus.a : bus.a;
  assign w_abs_b = w_sb ? -bus.b : bus.b;

  // Shift-add: accumulator in the upper half, multiplier consumed from the LSB
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mag_a} : '0);
  assign w_mul_step = {w_sum, r_acc[WIDTH-1:1]};

  // Restoring division: {rem, quot} shifted left, rem trial-subtracted at WIDTH+1 bits
  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge       = w_rem_sh >= {1'b0, r_mag_b};
  assign w_diff     = w_rem_sh[WIDTH-1:0] - r_mag_b;
  assign w_div_step = w_ge ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                           : {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  assign w_prod_fix = (r_sa ^ r_sb) ? -r_acc : r_acc;
  // Divide by zero always reports an all-ones quotient regardless of sign
  assign w_quot_fix = r_bzero ? '1
                    : ((r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
  assign w_rem_fix  = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (r_cnt == C_LAST) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = bus.start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div   <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_bzero <= 1'b0;
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      if (w_accept) begin
        r_div   <= bus.op[1];
        r_sa    <= w_sa;
        r_sb    <= w_sb;
        r_bzero <= (bus.b == '0);
        r_mag_a <= w_abs_a;
        r_mag_b <= w_abs_b;
        r_acc   <= {{WIDTH{1'b0}}, (bus.op[1] ? w_abs_a : w_abs_b)};
        r_cnt   <= '0;
      end else if (w_move) begin
        if (bus.mthi) r_hi <= bus.wdata;
        if (bus.mtlo) r_lo <= bus.wdata;
      end

      if (r_state == S_RUN) begin
        r_acc <= r_div ? w_div_step : w_mul_step;
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (r_state == S_FIX) begin
        if (r_div) begin
          r_hi <= w_rem_fix;
          r_lo <= w_quot_fix;
        end else begin
          r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
          r_lo <= w_prod_fix[WIDTH-1:0];
        end
      end
    end
  end

  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
  assign bus.busy = (r_state == S_RUN) || (r_state == S_FIX);
  assign bus.done = (r_state == S_DONE);

endmodule
`default_nettype wire
